// File: rtl/cmd_initiator.sv
// Command initiator: turns record read/write requests into UART byte
// transactions toward the controller and returns read data or ack status.
module cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic         req_count,
  input  logic [1:0]   req_type,
  input  logic [7:0]   req_index,
  input  logic [511:0] req_wdata,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [511:0] rsp_rdata,
  output logic         rsp_err
);

  localparam int unsigned DW = 512;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 6;
  localparam int unsigned TW = 32;

  localparam logic [CW-1:0] CNT_LAST = CW'(63);
  localparam logic [CW-1:0] ACK_LAST = CW'(3);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  // Acknowledge sequence, first expected byte in the top lane
  localparam logic [31:0]   ACK_SEQ  = 32'h656E_6F44;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_IDX,
    SEND_DATA,
    RECV_DATA,
    RECV_ACK,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            write_q, write_d;
  logic [BW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [DW-1:0]   rdata_d;
  logic            rsp_err_d;
  logic [BW-1:0]   tx_data_d;
  logic            req_ready_d;
  logic            tx_valid_d;
  logic            rsp_valid_d;
  logic [BW-1:0]   ack_exp;
  logic            ack_mis;

  // RX is always drained; bytes outside the receive states are dropped
  assign rx_ready = 1'b1;

  // Expected ack byte for the current position in the sequence
  assign ack_exp = ACK_SEQ[{~cnt_q[1:0], 3'b000} +: BW];
  assign ack_mis = (rx_data != ack_exp);

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      shift_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      tx_data   <= '0;
      req_ready <= 1'b0;
      tx_valid  <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= rsp_err_d;
      tx_data   <= tx_data_d;
      req_ready <= req_ready_d;
      tx_valid  <= tx_valid_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    write_d   = write_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rdata_d   = rsp_rdata;
    rsp_err_d = rsp_err;
    tx_data_d = tx_data;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d   = req_write;
          idx_d     = req_count ? '0 : req_index;
          shift_d   = req_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
          cnt_d     = '0;
          tmo_d     = '0;
          tx_data_d = req_count ? {~req_write, 7'h7F} : {~req_write, 5'b0, req_type};
          state_d   = SEND_CMD;
        end
      end
      SEND_CMD: begin
        if (tx_ready) begin
          tx_data_d = idx_q;
          state_d   = SEND_IDX;
        end
      end
      SEND_IDX: begin
        if (tx_ready) begin
          cnt_d = '0;
          tmo_d = '0;
          if (write_q) begin
            tx_data_d = shift_q[DW-1 -: BW];
            state_d   = SEND_DATA;
          end else begin
            tx_data_d = '0;
            state_d   = RECV_DATA;
          end
        end
      end
      SEND_DATA: begin
        // Payload leaves MSB first through a left-shifting register
        if (tx_ready) begin
          shift_d   = shift_q << BW;
          tx_data_d = shift_q[DW-BW-1 -: BW];
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            tx_data_d = '0;
            tmo_d     = '0;
            state_d   = RECV_ACK;
          end
        end
      end
      RECV_DATA: begin
        // A byte in the expiry cycle wins over the timeout
        if (rx_valid) begin
          rdata_d[{cnt_q, 3'b000} +: BW] = rx_data;
          cnt_d = cnt_q + CW'(1);
          tmo_d = '0;
          if (cnt_q == CNT_LAST) begin
            rsp_err_d = 1'b0;
            state_d   = RESP;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_err_d = 1'b1;
          cnt_d     = '0;
          tmo_d     = '0;
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RECV_ACK: begin
        // Mismatches are sticky but all four bytes are always consumed
        if (rx_valid) begin
          err_d = err_q | ack_mis;
          cnt_d = cnt_q + CW'(1);
          tmo_d = '0;
          if (cnt_q == ACK_LAST) begin
            rsp_err_d = err_q | ack_mis;
            rdata_d   = '0;
            cnt_d     = '0;
            state_d   = RESP;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_err_d = 1'b1;
          cnt_d     = '0;
          tmo_d     = '0;
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    tx_valid_d  = (state_d == SEND_CMD) || (state_d == SEND_IDX) || (state_d == SEND_DATA);
    rsp_valid_d = (state_d == RESP);
  end

endmodule

// File: tb/tb_cmd_initiator.sv
// Directed bench for cmd_initiator with hand-computed expectations.
module tb_cmd_initiator;

  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_count;
  logic [1:0]   req_type;
  logic [7:0]   req_index;
  logic [511:0] req_wdata;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [511:0] rsp_rdata;
  logic         rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  cmd_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_count (req_count),
    .req_type  (req_type),
    .req_index (req_index),
    .req_wdata (req_wdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request once req_ready is seen
  task automatic issue(input logic w, input logic c, input logic [1:0] t,
                       input logic [7:0] i, input logic [511:0] d);
    int k = 0;
    while (!req_ready && k < 20) begin step(); k++; end
    chk("req_ready before request", 512'(req_ready), 512'(1));
    req_write = w; req_count = c; req_type = t; req_index = i; req_wdata = d;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Take one TX byte (tx_ready held high) and compare it
  task automatic get_tx(input string tag, input logic [7:0] exp);
    int k = 0;
    while (!(tx_valid && tx_ready) && k < 20) begin step(); k++; end
    chk($sformatf("%s tx_valid", tag), 512'(tx_valid), 512'(1));
    chk(tag, 512'(tx_data), 512'(exp));
    step();
  endtask

  task automatic put_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  // Check the pending response, optionally stall it, then complete the handshake
  task automatic finish_rsp(input string tag, input logic [511:0] exp_d,
                            input logic exp_e, input int hold);
    int k = 0;
    while (!rsp_valid && k < 200) begin step(); k++; end
    chk($sformatf("%s rsp_valid", tag), 512'(rsp_valid), 512'(1));
    chk($sformatf("%s rsp_err", tag), 512'(rsp_err), 512'(exp_e));
    chk($sformatf("%s rsp_rdata", tag), rsp_rdata, exp_d);
    for (int h = 0; h < hold; h++) begin
      step();
      chk($sformatf("%s stall%0d rsp_valid", tag, h), 512'(rsp_valid), 512'(1));
      chk($sformatf("%s stall%0d rsp_rdata", tag, h), rsp_rdata, exp_d);
      chk($sformatf("%s stall%0d req_ready", tag, h), 512'(req_ready), 512'(0));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk($sformatf("%s rsp_valid drop", tag), 512'(rsp_valid), 512'(0));
    chk($sformatf("%s back to idle", tag), 512'(req_ready), 512'(1));
  endtask

  // Complete 64-byte read with incrementing RX data starting at base
  task automatic read_full(input string tag, input logic [1:0] t, input logic [7:0] i,
                           input logic [7:0] exp_cmd, input logic [7:0] base, input int hold);
    logic [511:0] e;
    e = '0;
    issue(1'b0, 1'b0, t, i, '0);
    get_tx($sformatf("%s cmd", tag), exp_cmd);
    get_tx($sformatf("%s idx", tag), i);
    for (int k = 0; k < 64; k++) begin
      put_rx(base + 8'(k));
      e[k*8 +: 8] = base + 8'(k);
    end
    chk($sformatf("%s rsp right after 64th byte", tag), 512'(rsp_valid), 512'(1));
    chk($sformatf("%s byte0", tag), 512'(rsp_rdata[7:0]), 512'(base));
    chk($sformatf("%s byte63", tag), 512'(rsp_rdata[511:504]), 512'(base + 8'h3F));
    finish_rsp(tag, e, 1'b0, hold);
  endtask

  initial begin
    logic [511:0] wd;
    logic [511:0] ep;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_count = 1'b0;
    req_type = '0; req_index = '0; req_wdata = '0; tx_ready = 1'b1;
    rx_data = '0; rx_valid = 1'b0; rsp_ready = 1'b0;

    // Reset values
    #12;
    chk("rst req_ready", 512'(req_ready), 512'(0));
    chk("rst tx_valid", 512'(tx_valid), 512'(0));
    chk("rst tx_data", 512'(tx_data), 512'(0));
    chk("rst rx_ready", 512'(rx_ready), 512'(1));
    chk("rst rsp_valid", 512'(rsp_valid), 512'(0));
    chk("rst rsp_err", 512'(rsp_err), 512'(0));
    chk("rst rsp_rdata", rsp_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    chk("post-rst req_ready", 512'(req_ready), 512'(1));
    chk("post-rst tx_valid", 512'(tx_valid), 512'(0));

    // Read type 3 index 5, response stalled 5 cycles
    read_full("rd_t3_i5", 2'd3, 8'h05, 8'h83, 8'h00, 5);

    // Write count record: index forced to 0, payload 512'h01
    issue(1'b1, 1'b1, 2'd2, 8'hAA, 512'h01);
    get_tx("wc cmd", 8'h7F);
    get_tx("wc idx", 8'h00);
    for (int k = 0; k < 63; k++) get_tx($sformatf("wc data%0d", k), 8'h00);
    get_tx("wc data63", 8'h01);
    chk("wc tx_valid after data", 512'(tx_valid), 512'(0));
    put_rx(8'h65); put_rx(8'h6E); put_rx(8'h6F); put_rx(8'h44);
    finish_rsp("wc ack ok", '0, 1'b0, 0);

    // Write type 2 with a corrupted third ack byte
    wd = '0;
    for (int k = 0; k < 64; k++) wd[k*8 +: 8] = 8'h40 + 8'(k);
    issue(1'b1, 1'b0, 2'd2, 8'h12, wd);
    get_tx("wbad cmd", 8'h02);
    get_tx("wbad idx", 8'h12);
    for (int k = 63; k >= 0; k--) get_tx($sformatf("wbad data%0d", k), 8'h40 + 8'(k));
    put_rx(8'h65); put_rx(8'h6E); put_rx(8'h00);
    chk("wbad no rsp before 4th ack", 512'(rsp_valid), 512'(0));
    put_rx(8'h44);
    chk("wbad rsp after 4th ack", 512'(rsp_valid), 512'(1));
    finish_rsp("wbad", '0, 1'b1, 0);

    // Read with only 10 bytes: timeout exactly 16 cycles after the last
    issue(1'b0, 1'b0, 2'd0, 8'h07, '0);
    get_tx("rto cmd", 8'h80);
    get_tx("rto idx", 8'h07);
    ep = '0;
    for (int k = 0; k < 10; k++) begin
      put_rx(8'hA0 + 8'(k));
      ep[k*8 +: 8] = 8'hA0 + 8'(k);
    end
    repeat (15) step();
    chk("rto no rsp at 15", 512'(rsp_valid), 512'(0));
    step();
    chk("rto rsp at 16", 512'(rsp_valid), 512'(1));
    finish_rsp("rto", ep, 1'b1, 0);

    // Byte arriving in the expiry cycle is taken and the timeout ignored
    issue(1'b0, 1'b0, 2'd1, 8'h21, '0);
    get_tx("rrace cmd", 8'h81);
    get_tx("rrace idx", 8'h21);
    put_rx(8'h11);
    repeat (15) step();
    put_rx(8'h22);
    chk("rrace byte beats timeout", 512'(rsp_valid), 512'(0));
    repeat (15) step();
    chk("rrace no rsp at 15", 512'(rsp_valid), 512'(0));
    step();
    ep = '0;
    ep[7:0] = 8'h11;
    ep[15:8] = 8'h22;
    finish_rsp("rrace", ep, 1'b1, 0);

    // TX stall in SEND_DATA, then reset mid-transfer
    wd = '0;
    for (int k = 0; k < 64; k++) wd[k*8 +: 8] = 8'h80 + 8'(k);
    issue(1'b1, 1'b0, 2'd1, 8'h03, wd);
    get_tx("stall cmd", 8'h01);
    get_tx("stall idx", 8'h03);
    get_tx("stall data63", 8'hBF);
    tx_ready = 1'b0;
    step();
    chk("stall1 tx_valid", 512'(tx_valid), 512'(1));
    chk("stall1 tx_data", 512'(tx_data), 512'(8'hBE));
    step();
    chk("stall2 tx_valid", 512'(tx_valid), 512'(1));
    chk("stall2 tx_data", 512'(tx_data), 512'(8'hBE));
    tx_ready = 1'b1;
    get_tx("stall data62", 8'hBE);
    get_tx("stall data61", 8'hBD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst tx_valid", 512'(tx_valid), 512'(0));
    chk("midrst tx_data", 512'(tx_data), 512'(0));
    chk("midrst req_ready", 512'(req_ready), 512'(0));
    chk("midrst rsp_valid", 512'(rsp_valid), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    chk("after midrst req_ready", 512'(req_ready), 512'(1));
    chk("after midrst tx_valid", 512'(tx_valid), 512'(0));
    chk("after midrst rsp_valid", 512'(rsp_valid), 512'(0));
    read_full("rd_after_rst", 2'd2, 8'h09, 8'h82, 8'h30, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
